// File: rtl/div_req_arbiter_if.sv
// Handshake bundle between the two operand front-ends, the result consumer and
// the shared divider core. The arbiter connects through the slave modport.
interface div_req_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_dividend;
  logic [WIDTH-1:0] req0_divisor;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_dividend;
  logic [WIDTH-1:0] req1_divisor;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic [1:0]       rsp_err;

  logic             core_start;
  logic [WIDTH-1:0] core_dividend;
  logic [WIDTH-1:0] core_divisor;
  logic             core_done;
  logic [WIDTH-1:0] core_quotient;
  logic [WIDTH-1:0] core_remainder;

  logic             busy;

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  rsp_ready, core_done, core_quotient, core_remainder,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
    output core_start, core_dividend, core_divisor, busy
  );

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output rsp_ready, core_done, core_quotient, core_remainder,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
    input  core_start, core_dividend, core_divisor, busy
  );
endinterface

// File: rtl/div_req_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters,
// with divide-by-zero short-cut and a watchdog on the core's done pulse.
module div_req_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 24
) (
  input  logic             clk,
  input  logic             rst,
  div_req_arbiter_if.slave bus
);
  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_dividend, r_divisor, r_quotient, r_remainder;
  logic [1:0]       r_err;
  logic             r_id, r_last_grant;
  logic [TW-1:0]    r_timer;

  logic             w_grant_id, w_accept, w_div_zero, w_timeout;
  logic [WIDTH-1:0] w_sel_dividend, w_sel_divisor;

  // On a tie the requester not served last wins; otherwise whoever is valid.
  assign w_grant_id     = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
  assign w_accept       = (r_state == S_IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
  assign w_sel_dividend = w_grant_id ? bus.req1_dividend : bus.req0_dividend;
  assign w_sel_divisor  = w_grant_id ? bus.req1_divisor  : bus.req0_divisor;
  assign w_div_zero     = (w_sel_divisor == '0);
  assign w_timeout      = (r_timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_div_zero ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.core_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.core_start = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        bus.req0_ready = w_accept && !w_grant_id;
        bus.req1_ready = w_accept &&  w_grant_id;
      end
      S_ISSUE: bus.core_start = 1'b1;
      S_RESP:  bus.rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand/result registers are reset too, since they drive outputs that must read 0.
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quotient   <= '0;
      r_remainder  <= '0;
      r_err        <= 2'b00;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_timer      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_dividend   <= w_sel_dividend;
          r_divisor    <= w_sel_divisor;
          r_id         <= w_grant_id;
          r_last_grant <= w_grant_id;
          if (w_div_zero) begin
            r_quotient  <= '1;
            r_remainder <= w_sel_dividend;
            r_err       <= 2'b01;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          // A done pulse on the final watchdog cycle still counts as success.
          if (bus.core_done) begin
            r_quotient  <= bus.core_quotient;
            r_remainder <= bus.core_remainder;
            r_err       <= 2'b00;
          end else if (w_timeout) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_err       <= 2'b10;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_id        = r_id;
  assign bus.rsp_quotient  = r_quotient;
  assign bus.rsp_remainder = r_remainder;
  assign bus.rsp_err       = r_err;
  assign bus.core_dividend = r_dividend;
  assign bus.core_divisor  = r_divisor;
endmodule

// File: tb/tb_div_req_arbiter.sv
// Bench for div_req_arbiter: behavioural divider core, directed corner cases,
// a table of vectors and randomized operations against a reference model.
module tb_div_req_arbiter;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 24;

  typedef struct {
    logic       v0, v1;
    logic [7:0] a0, b0, a1, b1;
    logic       exp_id;
    logic [7:0] exp_q, exp_r;
    logic [1:0] exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  div_req_arbiter_if #(.WIDTH(WIDTH)) bus ();
  div_req_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int   n_tests = 0, n_fail = 0;
  int   core_lat = 3;
  bit   core_hang = 1'b0;
  int   start_cnt = 0, done_cnt = 0, stray_req = 0, stray_done = 0, op_unstable = 0;
  logic m_last;
  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v0, v1, a0, b0, a1, b1, id, q, r, err);
    vec_t v;
    v.v0 = 1'(v0); v.v1 = 1'(v1);
    v.a0 = 8'(a0); v.b0 = 8'(b0); v.a1 = 8'(a1); v.b1 = 8'(b1);
    v.exp_id = 1'(id); v.exp_q = 8'(q); v.exp_r = 8'(r); v.exp_err = 2'(err);
    return v;
  endfunction

  function automatic logic [63:0] rsp_vec();
    return 64'({bus.rsp_id, bus.rsp_err, bus.rsp_quotient, bus.rsp_remainder});
  endfunction

  function automatic logic [63:0] exp_vec(input int id, err, q, r);
    return 64'({1'(id), 2'(err), 8'(q), 8'(r)});
  endfunction

  // Divider core: done pulse core_lat cycles after the start pulse, unless hung.
  initial begin
    logic [7:0] a, b;
    int         cnt;
    bit         pend, stab;
    pend = 1'b0; stab = 1'b0; cnt = 0; a = '0; b = '0;
    bus.core_done = 1'b0; bus.core_quotient = '0; bus.core_remainder = '0;
    forever begin
      @(negedge clk);
      bus.core_done = 1'b0;
      if (bus.core_start === 1'b1) begin
        start_cnt++;
        a = bus.core_dividend; b = bus.core_divisor;
        cnt = core_lat; pend = !core_hang; stab = 1'b1;
      end else if (pend) begin
        if (rst) stab = 1'b0;
        if (stab && (bus.core_dividend !== a || bus.core_divisor !== b)) op_unstable++;
        cnt--;
        if (cnt <= 0) begin
          pend = 1'b0; done_cnt++;
          bus.core_done = 1'b1; bus.core_quotient = a / b; bus.core_remainder = a % b;
        end
      end
      if (stray_req != stray_done) begin
        stray_done++;
        bus.core_done = 1'b1; bus.core_quotient = 8'hAA; bus.core_remainder = 8'h55;
      end
    end
  end

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check({tag, "/outputs_zero"},
          64'({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.core_start, bus.busy,
               bus.rsp_id, bus.rsp_err, bus.rsp_quotient, bus.rsp_remainder,
               bus.core_dividend, bus.core_divisor}), 64'(0));
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic do_op(input string tag, input vec_t v, input int lat, input bit rnd_ready);
    bit got;
    got = 1'b0;
    core_lat = lat;
    @(posedge clk); #1;
    bus.req0_valid = v.v0; bus.req0_dividend = v.a0; bus.req0_divisor = v.b0;
    bus.req1_valid = v.v1; bus.req1_dividend = v.a1; bus.req1_divisor = v.b1;
    #1;
    check({tag, "/grant"}, 64'({bus.req1_ready, bus.req0_ready}), 64'(v.exp_id ? 2'b10 : 2'b01));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      bus.rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        got = 1'b1;
        check({tag, "/rsp"}, rsp_vec(),
              exp_vec(int'(v.exp_id), int'(v.exp_err), int'(v.exp_q), int'(v.exp_r)));
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    if (!got) check({tag, "/rsp_timeout"}, 64'(got), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         k, s0, d0, bad, n;
    logic [3:0] ids;
    logic [63:0] snap;
    vec_t       v;
    logic [7:0] a, b;

    bus.req0_dividend = '0; bus.req0_divisor = '0;
    bus.req1_dividend = '0; bus.req1_divisor = '0;
    do_reset("reset", 2);

    // Plain operation through the core.
    s0 = start_cnt;
    do_op("op_100_7", mk(1, 0, 100, 7, 0, 0, 0, 14, 2, 0), 5, 1'b0);
    check("op_100_7/one_start", 64'(start_cnt - s0), 64'(1));

    // Divide by zero: response the cycle after accept, core untouched.
    @(posedge clk); #1;
    s0 = start_cnt;
    bus.req1_valid = 1'b1; bus.req1_dividend = 8'd200; bus.req1_divisor = 8'd0;
    #1;
    check("div0/grant", 64'({bus.req1_ready, bus.req0_ready}), 64'(2'b10));
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    check("div0/rsp_next_cycle", 64'({bus.rsp_valid, rsp_vec()[18:0]}),
          64'({1'b1, exp_vec(1, 1, 255, 200)[18:0]}));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("div0/no_core_start", 64'(start_cnt - s0), 64'(0));
    check("div0/idle_again", 64'(bus.busy), 64'(0));

    // Hung core: watchdog abort, late done ignored, next op unaffected.
    core_hang = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_dividend = 8'd77; bus.req0_divisor = 8'd5;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    k = 1;
    while (!bus.rsp_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("tmo/cycles_from_accept", 64'(k), 64'(26));
    check("tmo/result", rsp_vec(), exp_vec(0, 2, 0, 0));
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    check("tmo/late_done_ignored", 64'({bus.rsp_valid, rsp_vec()[18:0]}),
          64'({1'b1, exp_vec(0, 2, 0, 0)[18:0]}));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    core_hang = 1'b0;
    do_op("tmo/next_op", mk(1, 0, 50, 7, 0, 0, 0, 7, 1, 0), 4, 1'b0);

    // Consumer stalls for 10 cycles while both requesters wait.
    core_lat = 3;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_dividend = 8'd123; bus.req0_divisor = 8'd10;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    snap = rsp_vec();
    check("stall/result", snap, exp_vec(0, 0, 12, 3));
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      #1;
      if (!bus.rsp_valid || bus.req0_ready || bus.req1_ready || rsp_vec() !== snap) bad++;
      @(posedge clk); #1;
    end
    check("stall/stable_no_accept", 64'(bad), 64'(0));
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Reset while waiting on the core; its eventual done must be ignored.
    d0 = done_cnt;
    core_lat = 12;
    bus.req0_valid = 1'b1; bus.req0_dividend = 8'd9; bus.req0_divisor = 8'd2;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstwait/in_wait", 64'({bus.busy, bus.rsp_valid}), 64'(2'b10));
    do_reset("rstwait", 1);
    bad = 0;
    for (int j = 0; j < 30 && done_cnt == d0; j++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.rsp_valid || bus.core_start) bad++;
    end
    @(posedge clk); #1;
    if (bus.busy || bus.rsp_valid) bad++;
    check("rstwait/stray_done_ignored", 64'({done_cnt != d0, 8'(bad)}), 64'({1'b1, 8'd0}));
    do_op("rstwait/next_9_3", mk(1, 0, 9, 3, 0, 0, 0, 3, 0, 0), 4, 1'b0);

    // Both requesters held valid: strict alternation starting with req0.
    do_reset("alt", 2);
    core_lat = 2;
    bus.req0_dividend = 8'd20; bus.req0_divisor = 8'd6;
    bus.req1_dividend = 8'd21; bus.req1_divisor = 8'd0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
    ids = '0; n = 0;
    for (int j = 0; j < 80 && n < 4; j++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        ids[n] = bus.rsp_id;
        n++;
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("alt/order_0101", 64'({n == 4, ids}), 64'({1'b1, 4'b1010}));

    // Table of vectors; expectations worked out by hand from last_grant=1 after reset.
    vecs[0] = mk(1, 0, 100,   7,   0,  0, 0,  14,   2, 0);
    vecs[1] = mk(0, 1,   0,   0, 200,  0, 1, 255, 200, 1);
    vecs[2] = mk(1, 1,   9,   3,  50,  5, 0,   3,   0, 0);
    vecs[3] = mk(1, 1,   9,   3,  50,  5, 1,  10,   0, 0);
    vecs[4] = mk(0, 1,   0,   0, 255, 16, 1,  15,  15, 0);
    vecs[5] = mk(1, 1,   0,   5,   7,  2, 0,   0,   0, 0);
    vecs[6] = mk(1, 0,   1, 255,   0,  0, 0,   0,   1, 0);
    vecs[7] = mk(0, 1,   0,   0, 255,  1, 1, 255,   0, 0);
    vecs[8] = mk(1, 0,   0,   0,   0,  0, 0, 255,   0, 1);
    do_reset("table", 2);
    for (int i = 0; i < 9; i++) do_op($sformatf("vec%0d", i), vecs[i], 1 + (i % (WIDTH + 2)), 1'b0);

    // Randomized operations against the reference model.
    do_reset("rnd", 2);
    for (int i = 0; i < 60; i++) begin
      v.v0 = 1'($urandom_range(0, 1)); v.v1 = 1'($urandom_range(0, 1));
      v.a0 = 8'($urandom); v.a1 = 8'($urandom);
      v.b0 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      v.b1 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      if (!v.v0 && !v.v1) begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;
        check($sformatf("rnd%0d/no_grant", i), 64'({bus.req1_ready, bus.req0_ready}), 64'(0));
        continue;
      end
      v.exp_id = (v.v0 && v.v1) ? ~m_last : v.v1;
      a = v.exp_id ? v.a1 : v.a0;
      b = v.exp_id ? v.b1 : v.b0;
      if (b == 8'd0) begin
        v.exp_q = 8'hFF; v.exp_r = a; v.exp_err = 2'b01;
      end else begin
        v.exp_q = a / b; v.exp_r = a % b; v.exp_err = 2'b00;
      end
      m_last = v.exp_id;
      do_op($sformatf("rnd%0d", i), v, int'($urandom_range(1, WIDTH + 2)), 1'b1);
    end

    check("core/operands_stable", 64'(op_unstable), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
